// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 receiver feeding a header/payload/checksum frame parser.
// Ports: clk50, rst (async, high), rx (serial in), clr (sync clear);
//   data (last good frame, channel k at [k*CH_W +: CH_W]), valid/err
//   one-cycle pulses, err_code (01 sum, 10 framing, 11 timeout), frame_cnt.
module uart_frame_rx #(
  parameter int          CLK_HZ  = 50_000_000,
  parameter int          BAUD    = 115_200,
  parameter int          NCH     = 3,
  parameter int          CH_W    = 32,
  parameter logic [7:0]  HDR     = 8'hA5,
  parameter int          TO_BITS = 20
) (
  input  logic                clk50,
  input  logic                rst,
  input  logic                rx,
  input  logic                clr,
  output logic [NCH*CH_W-1:0] data,
  output logic                valid,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [15:0]         frame_cnt
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int NB  = NCH * CH_W / 8;
  localparam int TO  = TO_BITS * DIV;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(TO + 1);
  localparam int IW  = $clog2(NB + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(DIV - 1);
  localparam logic [TW-1:0] TO_M1    = TW'(TO - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [1:0] {P_HDR, P_DATA, P_SUM} p_st_t;

  // synchronizer and edge detect
  logic r_sync1, r_sync2, r_prev;
  logic [1:0] r_fill;
  logic w_fall;

  // r_prev only follows the line once the synchronizer holds real samples,
  // so a line held low out of reset never looks like a falling edge.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b0;
      r_fill  <= 2'b00;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      r_prev  <= r_sync2 & r_fill[1];
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  // byte receiver
  rx_st_t r_rs, w_rs_nx;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic w_tick_h, w_tick, w_stb, w_ferr;

  assign w_tick_h = (r_cnt == HALF_M1);
  assign w_tick   = (r_cnt == FULL_M1);

  always_comb begin
    w_rs_nx = r_rs;
    w_stb   = 1'b0;
    w_ferr  = 1'b0;
    unique case (r_rs)
      R_IDLE:  if (w_fall) w_rs_nx = R_START;
      R_START: if (w_tick_h) w_rs_nx = r_sync2 ? R_IDLE : R_DATA;
      R_DATA:  if (w_tick && r_bit == 3'd7) w_rs_nx = R_STOP;
      R_STOP: begin
        if (w_tick) begin
          w_rs_nx = R_IDLE;
          w_stb   = r_sync2;
          w_ferr  = ~r_sync2;
        end
      end
      default: w_rs_nx = R_IDLE;
    endcase
    if (clr) begin
      w_rs_nx = R_IDLE;
      w_stb   = 1'b0;
      w_ferr  = 1'b0;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) r_rs <= R_IDLE;
    else     r_rs <= w_rs_nx;
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else begin
      if (w_rs_nx != r_rs || r_rs == R_IDLE || (r_rs == R_DATA && w_tick))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (r_rs == R_START) begin
        r_bit <= '0;
      end else if (r_rs == R_DATA && w_tick) begin
        r_bit <= r_bit + 3'd1;
        r_sh  <= {r_sync2, r_sh[7:1]};
      end
    end
  end

  // frame parser
  p_st_t r_ps, w_ps_nx;
  logic [IW-1:0]       r_idx;
  logic [7:0]          r_sum;
  logic [TW-1:0]       r_to;
  logic [NCH*CH_W-1:0] r_shadow, r_data;
  logic [15:0]         r_fcnt;
  logic [1:0]          r_code;
  logic r_valid, r_err;
  logic w_to, w_good, w_bad, w_tmo;

  assign w_to  = (r_ps != P_HDR) && (r_to == TO_M1);
  // a strobe in the same cycle as the timeout wins
  assign w_tmo = w_to & ~w_stb & ~w_ferr & ~clr;

  always_comb begin
    w_ps_nx = r_ps;
    w_good  = 1'b0;
    w_bad   = 1'b0;
    if (w_ferr) begin
      w_ps_nx = P_HDR;
    end else if (w_stb) begin
      unique case (r_ps)
        P_HDR:  if (r_sh == HDR) w_ps_nx = P_DATA;
        P_DATA: if (r_idx == IDX_LAST) w_ps_nx = P_SUM;
        P_SUM: begin
          w_ps_nx = P_HDR;
          w_good  = (r_sh == r_sum);
          w_bad   = (r_sh != r_sum);
        end
        default: w_ps_nx = P_HDR;
      endcase
    end else if (w_to) begin
      w_ps_nx = P_HDR;
    end
    if (clr) begin
      w_ps_nx = P_HDR;
      w_good  = 1'b0;
      w_bad   = 1'b0;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) r_ps <= P_HDR;
    else     r_ps <= w_ps_nx;
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_sum    <= '0;
      r_to     <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_fcnt   <= '0;
      r_code   <= 2'b00;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (clr) begin
      r_idx   <= '0;
      r_sum   <= '0;
      r_to    <= '0;
      r_data  <= '0;
      r_fcnt  <= '0;
      r_code  <= 2'b00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_good;
      r_err   <= w_ferr | w_bad | w_tmo;
      if (w_ferr)     r_code <= 2'b10;
      else if (w_bad) r_code <= 2'b01;
      else if (w_tmo) r_code <= 2'b11;
      if (w_good) begin
        r_data <= r_shadow;
        r_fcnt <= r_fcnt + 16'd1;
      end
      if (w_stb && r_ps == P_HDR) begin
        r_idx <= '0;
        r_sum <= '0;
      end
      if (w_stb && r_ps == P_DATA) begin
        r_shadow[{r_idx, 3'b000} +: 8] <= r_sh;
        r_sum <= r_sum + r_sh;
        r_idx <= r_idx + IW'(1);
      end
      if (w_stb || w_ps_nx == P_HDR) r_to <= '0;
      else                           r_to <= r_to + TW'(1);
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign err       = r_err;
  assign err_code  = r_code;
  assign frame_cnt = r_fcnt;

endmodule
